// File: rtl/unsharp_mask_axis.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : unsharp_mask_axis
//  Purpose  : AXI4-Stream unsharp-mask sharpener, out = raw + gain*(raw-gaus),
//             with coring, saturation and a 4-stage stallable pipeline.
//  Option   : define SHARP_ROUND_EN for round-half-up gain scaling.
//  Revision : 1.0 - initial release
// ============================================================================
module unsharp_mask_axis #(
    parameter int DATA_WIDTH = 10,
    parameter int CHANNELS   = 1,
    parameter int FACTOR_W   = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic                           pixel_clk,
    input  logic                           rst_n,
    input  logic                           sharp_en,
    input  logic [DATA_WIDTH-1:0]          sharp_thr_in,
    input  logic [FACTOR_W-1:0]            sharp_gain_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tgaus,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser
);

    localparam int c_CW = DATA_WIDTH * CHANNELS;
    localparam int c_PW = DATA_WIDTH + FACTOR_W;
    localparam int c_SW = c_PW - FRAC_BITS;
    localparam int c_RW = c_PW + 2;
`ifdef SHARP_ROUND_EN
    localparam logic [c_PW-1:0] c_RND = c_PW'(1) << (FRAC_BITS - 1);
`else
    localparam logic [c_PW-1:0] c_RND = '0;
`endif

    logic w_ce, w_acc, w_load;
    logic                  w_cfg_en;
    logic [DATA_WIDTH-1:0] w_cfg_thr;
    logic [FACTOR_W-1:0]   w_cfg_gain;

    // Shadow configuration, held constant for the duration of a frame
    logic                  r_cfg_pend;
    logic                  r_sh_en;
    logic [DATA_WIDTH-1:0] r_sh_thr;
    logic [FACTOR_W-1:0]   r_sh_gain;

    // Stage 1
    logic                                  r_v1, r_l1, r_u1, r_en1;
    logic [DATA_WIDTH-1:0]                 r_thr1;
    logic [FACTOR_W-1:0]                   r_gain1;
    logic [c_CW-1:0]                       r_raw1, r_gaus1;
    logic [CHANNELS-1:0][DATA_WIDTH:0]     r_diff1, w_diff;
    // Stage 2
    logic                                  r_v2, r_l2, r_u2, r_en2;
    logic [FACTOR_W-1:0]                   r_gain2;
    logic [c_CW-1:0]                       r_raw2, r_gaus2;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]   r_mag2, w_mag;
    logic [CHANNELS-1:0]                   r_neg2, r_core2, w_core;
    // Stage 3
    logic                                  r_v3, r_l3, r_u3, r_en3;
    logic [c_CW-1:0]                       r_raw3, r_gaus3;
    logic [CHANNELS-1:0][c_SW-1:0]         r_scl3, w_scl;
    logic [CHANNELS-1:0]                   r_neg3, r_core3;
    // Stage 4 (output register)
    logic                                  r_v4, r_l4, r_u4;
    logic [c_CW-1:0]                       r_data4, w_out;

    assign w_ce          = m_axis_tready | ~r_v4;
    assign w_acc         = s_axis_tvalid & w_ce;
    assign w_load        = w_acc & (s_axis_tuser | r_cfg_pend);
    assign s_axis_tready = w_ce;

    // The loading beat itself must see the new values, hence the bypass mux
    assign w_cfg_en   = w_load ? sharp_en      : r_sh_en;
    assign w_cfg_thr  = w_load ? sharp_thr_in  : r_sh_thr;
    assign w_cfg_gain = w_load ? sharp_gain_in : r_sh_gain;

    assign m_axis_tdata  = r_data4;
    assign m_axis_tvalid = r_v4;
    assign m_axis_tlast  = r_l4;
    assign m_axis_tuser  = r_u4;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_pend <= 1'b1;
            r_sh_en    <= 1'b0;
            r_sh_thr   <= '0;
            r_sh_gain  <= '0;
        end else if (w_load) begin
            r_cfg_pend <= 1'b0;
            r_sh_en    <= sharp_en;
            r_sh_thr   <= sharp_thr_in;
            r_sh_gain  <= sharp_gain_in;
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [DATA_WIDTH-1:0] w_raw_in, w_gaus_in, w_clamp;
            logic [c_PW-1:0]       w_prod, w_prod_r;
            logic [c_RW-1:0]       w_raw_x, w_scl_x, w_res;

            assign w_raw_in  = s_axis_tdata[ch*DATA_WIDTH +: DATA_WIDTH];
            assign w_gaus_in = s_axis_tgaus[ch*DATA_WIDTH +: DATA_WIDTH];
            assign w_diff[ch] = {1'b0, w_raw_in} - {1'b0, w_gaus_in};

            assign w_mag[ch]  = r_diff1[ch][DATA_WIDTH] ? DATA_WIDTH'(-r_diff1[ch])
                                                        : r_diff1[ch][DATA_WIDTH-1:0];
            assign w_core[ch] = (w_mag[ch] <= r_thr1);

            assign w_prod    = c_PW'(r_mag2[ch]) * c_PW'(r_gain2);
            assign w_prod_r  = w_prod + c_RND;
            assign w_scl[ch] = c_SW'(w_prod_r >> FRAC_BITS);

            // Wide unsigned arithmetic: a negative result shows up in the top bit
            assign w_raw_x = c_RW'(r_raw3[ch*DATA_WIDTH +: DATA_WIDTH]);
            assign w_scl_x = c_RW'(r_scl3[ch]);
            assign w_res   = r_neg3[ch] ? (w_raw_x - w_scl_x) : (w_raw_x + w_scl_x);
            assign w_clamp = w_res[c_RW-1]                  ? '0 :
                             (|w_res[c_RW-2:DATA_WIDTH])    ? '1 :
                                                              w_res[DATA_WIDTH-1:0];
            assign w_out[ch*DATA_WIDTH +: DATA_WIDTH] =
                (!r_en3 || r_core3[ch]) ? r_gaus3[ch*DATA_WIDTH +: DATA_WIDTH] : w_clamp;
        end
    endgenerate

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0; r_l1 <= 1'b0; r_u1 <= 1'b0; r_en1 <= 1'b0;
            r_thr1 <= '0; r_gain1 <= '0; r_raw1 <= '0; r_gaus1 <= '0; r_diff1 <= '0;
            r_v2 <= 1'b0; r_l2 <= 1'b0; r_u2 <= 1'b0; r_en2 <= 1'b0;
            r_gain2 <= '0; r_raw2 <= '0; r_gaus2 <= '0; r_mag2 <= '0;
            r_neg2 <= '0; r_core2 <= '0;
            r_v3 <= 1'b0; r_l3 <= 1'b0; r_u3 <= 1'b0; r_en3 <= 1'b0;
            r_raw3 <= '0; r_gaus3 <= '0; r_scl3 <= '0; r_neg3 <= '0; r_core3 <= '0;
            r_v4 <= 1'b0; r_l4 <= 1'b0; r_u4 <= 1'b0; r_data4 <= '0;
        end else if (w_ce) begin
            r_v1    <= s_axis_tvalid;
            r_l1    <= s_axis_tlast;
            r_u1    <= s_axis_tuser;
            r_en1   <= w_cfg_en;
            r_thr1  <= w_cfg_thr;
            r_gain1 <= w_cfg_gain;
            r_raw1  <= s_axis_tdata;
            r_gaus1 <= s_axis_tgaus;
            r_diff1 <= w_diff;

            r_v2    <= r_v1;
            r_l2    <= r_l1;
            r_u2    <= r_u1;
            r_en2   <= r_en1;
            r_gain2 <= r_gain1;
            r_raw2  <= r_raw1;
            r_gaus2 <= r_gaus1;
            r_mag2  <= w_mag;
            r_core2 <= w_core;
            for (int i = 0; i < CHANNELS; i++) begin
                r_neg2[i] <= r_diff1[i][DATA_WIDTH];
            end

            r_v3    <= r_v2;
            r_l3    <= r_l2;
            r_u3    <= r_u2;
            r_en3   <= r_en2;
            r_raw3  <= r_raw2;
            r_gaus3 <= r_gaus2;
            r_scl3  <= w_scl;
            r_neg3  <= r_neg2;
            r_core3 <= r_core2;

            r_v4    <= r_v3;
            r_l4    <= r_l3;
            r_u4    <= r_u3;
            r_data4 <= w_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unsharp_mask_axis.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_unsharp_mask_axis
//  Purpose  : Self-checking bench for unsharp_mask_axis (vector table plus
//             scoreboarded stall, frame-config and reset sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unsharp_mask_axis;

    localparam int DW = 10;
    localparam int CH = 1;
    localparam int FW = 8;
    localparam int FB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sharp_en = 1'b0;
    logic [DW-1:0] thr = '0;
    logic [FW-1:0] gain = '0;
    logic [DW-1:0] s_tdata = '0, s_tgaus = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b1;

    always #5 clk = ~clk;

    unsharp_mask_axis #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .FACTOR_W   (FW),
        .FRAC_BITS  (FB)
    ) dut (
        .pixel_clk     (clk),
        .rst_n         (rst_n),
        .sharp_en      (sharp_en),
        .sharp_thr_in  (thr),
        .sharp_gain_in (gain),
        .s_axis_tdata  (s_tdata),
        .s_axis_tgaus  (s_tgaus),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } exp_t;

    typedef struct {
        int raw;
        int gaus;
        bit en;
        int thr;
        int gain;
        int exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    bit m_first = 1'b1;
    bit m_en    = 1'b0;
    int m_thr   = 0;
    int m_gain  = 0;
    bit rnd_done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model(input int raw, input int gaus, input bit en,
                                 input int thr_v, input int gain_v);
        int diff, mag, prod, scl, res;
        diff = raw - gaus;
        mag  = (diff < 0) ? -diff : diff;
        if (!en || mag <= thr_v) return gaus;
        prod = mag * gain_v;
`ifdef SHARP_ROUND_EN
        scl = (prod + (1 << (FB - 1))) >> FB;
`else
        scl = prod >> FB;
`endif
        res = (diff > 0) ? raw + scl : raw - scl;
        if (res < 0) res = 0;
        if (res > (1 << DW) - 1) res = (1 << DW) - 1;
        return res;
    endfunction

    // Drive one beat, wait for acceptance, then record the expected output
    task automatic send(input int raw, input int gaus, input bit en, input int thr_v,
                        input int gain_v, input bit last, input bit user, input int exp_v);
        int   wait_n;
        exp_t e;
        wait_n   = 0;
        s_tdata  = DW'(raw);
        s_tgaus  = DW'(gaus);
        sharp_en = en;
        thr      = DW'(thr_v);
        gain     = FW'(gain_v);
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready stayed %0d, required 1", s_tready);
        end else begin
            if (user || m_first) begin
                m_en    = en;
                m_thr   = thr_v;
                m_gain  = gain_v;
                m_first = 1'b0;
            end
            e.data = (exp_v < 0) ? DW'(model(raw, gaus, m_en, m_thr, m_gain)) : DW'(exp_v);
            e.last = last;
            e.user = user;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0d, required no beat", m_tdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tdata", int'(m_tdata), int'(e.data));
                chk("tlast", int'(m_tlast), int'(e.last));
                chk("tuser", int'(m_tuser), int'(e.user));
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   base;
        logic [DW-1:0] hold_d;
        logic hold_l;

        vecs[0]  = '{600, 500, 1'b1, 10,   32, 800};
        vecs[1]  = '{900, 500, 1'b1, 10,   32, 1023};
        vecs[2]  = '{100, 400, 1'b1, 10,   16, 0};
        vecs[3]  = '{505, 500, 1'b1, 10,   16, 500};
        vecs[4]  = '{700, 300, 1'b0, 0,    32, 300};
`ifdef SHARP_ROUND_EN
        vecs[5]  = '{500, 497, 1'b1, 0,    24, 505};
`else
        vecs[5]  = '{500, 497, 1'b1, 0,    24, 504};
`endif
        vecs[6]  = '{500, 500, 1'b1, 0,    32, 500};
        vecs[7]  = '{501, 500, 1'b1, 0,    16, 502};
        vecs[8]  = '{0,  1023, 1'b1, 0,   255, 0};
        vecs[9]  = '{1023,  0, 1'b1, 1023, 255, 0};
        vecs[10] = '{512, 500, 1'b1, 11,    0, 512};
        vecs[11] = '{300, 310, 1'b1, 5,    48, 270};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_tvalid", int'(m_tvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tready", int'(s_tready), 1);
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tdata",  int'(m_tdata), 0);
        chk("rst_tlast",  int'(m_tlast), 0);
        chk("rst_tuser",  int'(m_tuser), 0);
        @(posedge clk);
        #1;

        // Latency of a single SOF beat
        s_tdata = 10'd600; s_tgaus = 10'd500; sharp_en = 1'b1;
        thr = 10'd10; gain = 8'h20; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
        @(negedge clk);
        chk("lat_accept", int'(s_tready), 1);
        m_en = 1'b1; m_thr = 10; m_gain = 32; m_first = 1'b0;
        sb.push_back('{10'd800, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tuser = 1'b0;
        lat = 0;
        while (!m_tvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        drain("lat_drain");

        // Vector table, one single-beat frame per entry, back to back
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].raw, vecs[i].gaus, vecs[i].en, vecs[i].thr, vecs[i].gain,
                 1'b1, 1'b1, vecs[i].exp);
        end
        drain("table_drain");

        // Mid-frame gain change only applies from the next SOF
        send(600, 500, 1'b1, 10, 32, 1'b0, 1'b1, 800);
        send(600, 500, 1'b1, 10, 16, 1'b1, 1'b0, 800);
        send(600, 500, 1'b1, 10, 16, 1'b0, 1'b1, 700);
        send(640, 600, 1'b1, 10, 32, 1'b1, 1'b0, 680);
        drain("cfg_drain");

        // 16-beat line with a 3-cycle downstream stall at beat 6
        base = n_out;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    send(k * 40 + 100, k * 30 + 120, 1'b1, 4, 24, k == 15, k == 0, -1);
                end
            end
            begin
                int w;
                w = 0;
                while (n_out < base + 5 && w < 500) begin
                    @(posedge clk);
                    w++;
                end
                chk("stall_reach", int'(n_out >= base + 5), 1);
                #1;
                m_tready = 1'b0;
                @(negedge clk);
                chk("stall_valid",  int'(m_tvalid), 1);
                chk("stall_sready", int'(s_tready), 0);
                hold_d = m_tdata;
                hold_l = m_tlast;
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_hold_valid", int'(m_tvalid), 1);
                    chk("stall_hold_data",  int'(m_tdata), int'(hold_d));
                    chk("stall_hold_last",  int'(m_tlast), int'(hold_l));
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain("line_drain");
        chk("line_beats", n_out - base, 16);

        // Random data, config and backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                         $urandom_range(0, 3) != 0, int'($urandom_range(0, 40)),
                         int'($urandom_range(0, 255)), k == 39, (k % 10) == 0, -1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    m_tready = ($urandom_range(0, 1) == 1);
                end
                m_tready = 1'b1;
            end
        join
        drain("rand_drain");

        // Reset in the middle of a line
        for (int k = 0; k < 6; k++) begin
            send(200 + k * 50, 300, 1'b1, 2, 20, 1'b0, k == 0, -1);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", int'(m_tvalid), 0);
        chk("midrst_tdata",  int'(m_tdata), 0);
        sb.delete();
        m_first = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_tready", int'(s_tready), 1);
        chk("midrst_flushed", int'(m_tvalid), 0);
        @(posedge clk);
        #1;
        // First beat after reset loads config without SOF
        send(600, 500, 1'b1, 0, 32, 1'b0, 1'b0, 800);
        send(600, 500, 1'b1, 0, 16, 1'b1, 1'b0, 800);
        drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
